// File: rtl/cfg_frame_parser.sv
// rtl/cfg_frame_parser.sv - framed config record parser with word FIFO and source throttling
module cfg_frame_parser #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_enable,
    output logic                             o_pump_enable,
    input  logic                             i_data_valid,
    input  logic [DATA_WIDTH-1:0]            iv_data,
    output logic                             o_wr_valid,
    input  logic                             i_wr_ready,
    output logic [ADDR_WIDTH-1:0]            ov_wr_addr,
    output logic [DATA_WIDTH*WORD_BYTES-1:0] ov_wr_data,
    output logic                             o_frame_done,
    output logic                             o_frame_ok,
    output logic                             o_overflow,
    output logic [7:0]                       ov_err_cnt
);

    localparam int WW = DATA_WIDTH * WORD_BYTES;
    localparam int EW = ADDR_WIDTH + WW;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [DATA_WIDTH-1:0] SYNC = DATA_WIDTH'(8'hA5);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_PAY,
        S_CHK
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   csum;
    logic [DATA_WIDTH-1:0]   words_left;
    logic [BW-1:0]           byte_idx;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [WW-1:0]           word_sr;
    logic [WW-1:0]           next_word;

    // Word staged for the FIFO; it lands one cycle after its last byte
    logic                    push_req;
    logic [ADDR_WIDTH-1:0]   push_addr;
    logic [WW-1:0]           push_word;

    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_next;
    logic                    pop;
    logic                    full;
    logic                    push_ok;

    assign next_word = (word_sr << DATA_WIDTH) | WW'(iv_data);

    // Frame parser: advances only on valid bytes, tracks checksum and word assembly
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state        <= S_HUNT;
            csum         <= '0;
            words_left   <= '0;
            byte_idx     <= '0;
            cur_addr     <= '0;
            word_sr      <= '0;
            push_req     <= 1'b0;
            push_addr    <= '0;
            push_word    <= '0;
            o_frame_done <= 1'b0;
            o_frame_ok   <= 1'b0;
            ov_err_cnt   <= '0;
        end else begin
            push_req     <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_data_valid) begin
                case (state)
                    S_HUNT: begin
                        if (iv_data == SYNC) state <= S_ADDR;
                    end
                    S_ADDR: begin
                        cur_addr <= ADDR_WIDTH'(iv_data);
                        csum     <= iv_data;
                        state    <= S_LEN;
                    end
                    S_LEN: begin
                        if (iv_data == '0) begin
                            if (ov_err_cnt != 8'hFF) ov_err_cnt <= ov_err_cnt + 8'd1;
                            state <= S_HUNT;
                        end else begin
                            words_left <= iv_data;
                            csum       <= csum ^ iv_data;
                            byte_idx   <= '0;
                            state      <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        csum    <= csum ^ iv_data;
                        word_sr <= next_word;
                        if (byte_idx == BW'(WORD_BYTES - 1)) begin
                            push_req   <= 1'b1;
                            push_addr  <= cur_addr;
                            push_word  <= next_word;
                            cur_addr   <= cur_addr + 1'b1;
                            byte_idx   <= '0;
                            words_left <= words_left - 1'b1;
                            if (words_left == DATA_WIDTH'(1)) state <= S_CHK;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                    S_CHK: begin
                        o_frame_done <= 1'b1;
                        o_frame_ok   <= (csum == iv_data);
                        if (csum != iv_data && ov_err_cnt != 8'hFF)
                            ov_err_cnt <= ov_err_cnt + 8'd1;
                        state <= S_HUNT;
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

    assign pop        = o_wr_valid && i_wr_ready;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign push_ok    = push_req && (!full || pop);
    assign count_next = count + CW'(push_ok) - CW'(pop);

    // Output FIFO plus throttle; a pop while full frees the slot the push reuses
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_overflow    <= 1'b0;
            o_pump_enable <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {push_addr, push_word};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (push_req && !push_ok) o_overflow <= 1'b1;
            o_pump_enable <= i_enable && (count_next <= CW'(FIFO_DEPTH - 2));
        end
    end

    assign o_wr_valid = (count != '0);
    assign {ov_wr_addr, ov_wr_data} = mem[rd_ptr];

endmodule

// File: tb/tb_cfg_frame_parser.sv
// tb/tb_cfg_frame_parser.sv - scoreboard bench for cfg_frame_parser
module tb_cfg_frame_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pump;
    logic        valid;
    logic [7:0]  data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_done;
    logic        frame_ok;
    logic        overflow;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    cfg_frame_parser #(
        .DATA_WIDTH(8), .WORD_BYTES(4), .ADDR_WIDTH(8), .FIFO_DEPTH(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .o_pump_enable(pump),
        .i_data_valid(valid), .iv_data(data), .o_wr_valid(wr_valid),
        .i_wr_ready(wr_ready), .ov_wr_addr(wr_addr), .ov_wr_data(wr_data),
        .o_frame_done(frame_done), .o_frame_ok(frame_ok),
        .o_overflow(overflow), .ov_err_cnt(err_cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]  src_q [$];
    logic [39:0] exp_w [$];
    bit          exp_ok [$];
    int          max_gap = 0;
    int          gap = 0;
    int          err_exp = 0;
    logic        pump_s = 1'b0;
    bit          seen_throttle;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bump_err();
        if (err_exp < 255) err_exp++;
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] len,
                              input bit bad, input logic [31:0] first_word);
        logic [7:0]  x;
        logic [31:0] w;
        logic [7:0]  b;
        src_q.push_back(8'hA5);
        src_q.push_back(addr);
        src_q.push_back(len);
        if (len == 8'd0) begin
            bump_err();
            return;
        end
        x = addr ^ len;
        for (int i = 0; i < int'(len); i++) begin
            w = (i == 0) ? first_word : $urandom;
            for (int k = 3; k >= 0; k--) begin
                b = w[k*8 +: 8];
                src_q.push_back(b);
                x = x ^ b;
            end
            exp_w.push_back({addr + 8'(i), w});
        end
        src_q.push_back(bad ? ~x : x);
        exp_ok.push_back(!bad);
        if (bad) bump_err();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((src_q.size() != 0 || exp_w.size() != 0 || exp_ok.size() != 0) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", n >= 20000, 0);
        repeat (4) @(posedge clk);
    endtask

    // Byte source with one cycle of latency behind the pump enable
    initial begin
        valid = 1'b0;
        data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (pump_s && src_q.size() != 0 && gap == 0) begin
                valid = 1'b1;
                data  = src_q.pop_front();
                gap   = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            end else begin
                valid = 1'b0;
                if (gap > 0) gap--;
            end
        end
    end

    // Output monitor against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            pump_s = pump;
            if (!pump) seen_throttle = 1'b1;
            if (wr_valid && wr_ready) begin
                if (exp_w.size() == 0) check("extra_word", 1, 0);
                else check("word", {wr_addr, wr_data}, exp_w.pop_front());
            end
            if (frame_done) begin
                if (exp_ok.size() == 0) check("extra_done", 1, 0);
                else check("frame_ok", frame_ok, exp_ok.pop_front());
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0; enable = 1'b0; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {pump, wr_valid, wr_addr, wr_data, frame_done, frame_ok, overflow, err_cnt}, 0);
        @(posedge clk); #1;
        rst = 1'b1; enable = 1'b1;

        send_frame(8'h10, 8'd1, 1'b0, 32'hDEADBEEF);
        wait_idle();
        check("t1_err", err_cnt, err_exp);

        send_frame(8'h10, 8'd1, 1'b1, 32'hDEADBEEF);
        wait_idle();
        check("t2_err", err_cnt, 1);
        check("t2_ok_held", frame_ok, 0);

        src_q.push_back(8'h00); src_q.push_back(8'hFF); src_q.push_back(8'h5A);
        send_frame(8'hFE, 8'd3, 1'b0, 32'h01234567);
        wait_idle();
        check("t3_ok_held", frame_ok, 1);

        wr_ready = 1'b0;
        seen_throttle = 1'b0;
        send_frame(8'h40, 8'd8, 1'b0, 32'hCAFEF00D);
        n = 0;
        while (!seen_throttle && n < 500) begin @(posedge clk); n++; end
        check("t4_throttle", seen_throttle, 1);
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("t4_stalled_valid", wr_valid, 1);
        check("t4_stalled_pump", pump, 0);
        @(posedge clk); #1;
        wr_ready = 1'b1;
        wait_idle();
        check("t4_overflow", overflow, 0);

        max_gap = 5;
        send_frame(8'h80, 8'd2, 1'b0, 32'h11223344);
        send_frame(8'h81, 8'd0, 1'b0, 32'h0);
        send_frame(8'h82, 8'd1, 1'b0, 32'h55667788);
        wait_idle();
        check("t5_len0_err", err_cnt, err_exp);

        src_q.push_back(8'hA5); src_q.push_back(8'h20); src_q.push_back(8'h02);
        src_q.push_back(8'h99); src_q.push_back(8'h98);
        n = 0;
        while (src_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
        check("t5_partial_sent", n >= 500, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_outputs", {pump, wr_valid, wr_addr, wr_data, frame_done, frame_ok, overflow, err_cnt}, 0);
        err_exp = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        max_gap = 2;
        send_frame(8'h33, 8'd2, 1'b0, 32'hA5A5A5A5);
        wait_idle();
        check("t5_after_rst_err", err_cnt, 0);
        check("t5_after_rst_ok", frame_ok, 1);

        max_gap = 0;
        for (int i = 0; i < 300; i++) send_frame(8'(i), 8'd1, 1'b1, $urandom);
        wait_idle();
        check("t6_saturate", err_cnt, 255);
        check("t6_model_sat", err_cnt, err_exp);
        check("t6_overflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
